// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable
//   Byte-addressed instruction memory for the MIPS fetch stage. The boot loader
//   streams the program image in byte by byte. The IF stage then fetches 32-bit
//   words through a registered request/valid port with 1-cycle latency.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   load_start         enter LOAD, clear write pointer, count and overflow flag
//   load_valid/byte    program byte stream (LOAD only)
//   load_ready         a byte is accepted this cycle
//   load_end           leave LOAD for RUN
//   load_count         bytes loaded so far (0..DEPTH), doubles as write pointer
//   load_ovf           sticky: a byte was offered while memory was full
//   fetch_ready        fetch port open (RUN only)
//   fetch_req, pc      fetch request and byte address
//   instr, instr_valid fetched word and its one-cycle valid pulse
//   fetch_fault        bit0 misaligned pc, bit1 word beyond loaded image
//
// state  | meaning
// S_IDLE | after reset; nothing loaded, both ports closed
// S_LOAD | accepting program bytes
// S_RUN  | serving fetches from the loaded image
module instr_mem_loadable #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  input  logic              load_end,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf,
  output logic              fetch_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [1:0]        fetch_fault
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [ADDR_W:0] r_count;
  logic            r_ovf;
  logic [31:0]     r_instr;
  logic            r_valid;
  logic [1:0]      r_fault;

  logic            w_full;
  logic            w_load_ready;
  logic            w_wr;
  logic            w_drop;
  logic            w_accept;
  logic [ADDR_W:0] w_end_addr;
  logic [1:0]      w_fault;
  logic [7:0]      w_b0, w_b1, w_b2, w_b3;
  logic [31:0]     w_word;

  // Count never exceeds DEPTH, so its MSB alone marks a full memory.
  assign w_full       = r_count[ADDR_W];
  assign w_load_ready = (r_state == S_LOAD) && !w_full;
  // load_start restarts the image, so a byte offered alongside it is discarded.
  assign w_wr         = w_load_ready && load_valid && !load_start;
  assign w_drop       = (r_state == S_LOAD) && w_full && load_valid && !load_start;
  assign w_accept     = fetch_req && (r_state == S_RUN);

  // One extra bit so pc+4 near the top of memory compares without wrapping.
  assign w_end_addr = {1'b0, pc} + (ADDR_W+1)'(4);
  assign w_fault    = {(w_end_addr > r_count), (pc[1:0] != 2'b00)};

  // Bytes are addressed from the word base; low pc bits only matter as a fault.
  assign w_b0 = r_mem[{pc[ADDR_W-1:2], 2'd0}];
  assign w_b1 = r_mem[{pc[ADDR_W-1:2], 2'd1}];
  assign w_b2 = r_mem[{pc[ADDR_W-1:2], 2'd2}];
  assign w_b3 = r_mem[{pc[ADDR_W-1:2], 2'd3}];
  assign w_word = BIG_ENDIAN ? {w_b0, w_b1, w_b2, w_b3} : {w_b3, w_b2, w_b1, w_b0};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (load_start)    w_state_nxt = S_LOAD;
        else if (load_end) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (load_start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_fault <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_accept;
      if (w_accept) begin
        r_fault <= w_fault;
        r_instr <= (w_fault != 2'b00) ? 32'd0 : w_word;
      end
      if (load_start) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_wr)   r_count <= r_count + (ADDR_W+1)'(1);
        if (w_drop) r_ovf   <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; load_count gates what is reachable.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_count[ADDR_W-1:0]] <= load_byte;
  end

  assign load_ready  = w_load_ready;
  assign load_count  = r_count;
  assign load_ovf    = r_ovf;
  assign fetch_ready = (r_state == S_RUN);
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable. Two instances share one stimulus stream:
//   A: ADDR_W=8, big-endian   B: ADDR_W=4, little-endian (pc low 4 bits)
// A behavioural model (byte arrays + counters) predicts every output and is
// compared on each falling edge; directed sections add literal expectations.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0, load_valid = 1'b0, load_end = 1'b0, fetch_req = 1'b0;
  logic [7:0]  load_byte = 8'd0;
  logic [7:0]  pc = 8'd0;

  logic        a_load_ready, a_load_ovf, a_fetch_ready, a_instr_valid;
  logic [8:0]  a_load_count;
  logic [31:0] a_instr;
  logic [1:0]  a_fetch_fault;
  logic        b_load_ready, b_load_ovf, b_fetch_ready, b_instr_valid;
  logic [4:0]  b_load_count;
  logic [31:0] b_instr;
  logic [1:0]  b_fetch_fault;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_mem_loadable #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) u_a (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(a_load_ready), .load_end(load_end),
    .load_count(a_load_count), .load_ovf(a_load_ovf), .fetch_ready(a_fetch_ready),
    .fetch_req(fetch_req), .pc(pc), .instr(a_instr), .instr_valid(a_instr_valid),
    .fetch_fault(a_fetch_fault));

  instr_mem_loadable #(.ADDR_W(4), .BIG_ENDIAN(1'b0)) u_b (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(b_load_ready), .load_end(load_end),
    .load_count(b_load_count), .load_ovf(b_load_ovf), .fetch_ready(b_fetch_ready),
    .fetch_req(fetch_req), .pc(pc[3:0]), .instr(b_instr), .instr_valid(b_instr_valid),
    .fetch_fault(b_fetch_fault));

  // ---------------- behavioural model ----------------
  // m_state: 0 idle, 1 load, 2 run
  int          m_state [2];
  int          m_cnt   [2];
  bit          m_ovf   [2];
  bit          m_valid [2];
  logic [31:0] m_instr [2];
  logic [1:0]  m_fault [2];
  logic [7:0]  m_mem   [0:1][0:255];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
      m_valid[k] = 1'b0; m_instr[k] = 32'd0; m_fault[k] = 2'b00;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int dep;
      int p;
      logic [1:0] f;
      dep = (k == 0) ? 256 : 16;
      p   = (k == 0) ? int'(pc) : int'(pc[3:0]);
      if (fetch_req && m_state[k] == 2) begin
        f[0] = (p % 4) != 0;
        f[1] = (p + 4) > m_cnt[k];
        m_valid[k] = 1'b1;
        m_fault[k] = f;
        if (f != 2'b00)  m_instr[k] = 32'd0;
        else if (k == 0) m_instr[k] = {m_mem[k][p], m_mem[k][p+1], m_mem[k][p+2], m_mem[k][p+3]};
        else             m_instr[k] = {m_mem[k][p+3], m_mem[k][p+2], m_mem[k][p+1], m_mem[k][p]};
      end else begin
        m_valid[k] = 1'b0;
      end
      if (load_start) begin
        m_cnt[k] = 0; m_ovf[k] = 1'b0; m_state[k] = 1;
      end else begin
        if (m_state[k] == 1 && load_valid) begin
          if (m_cnt[k] < dep) begin
            m_mem[k][m_cnt[k]] = load_byte;
            m_cnt[k]++;
          end else begin
            m_ovf[k] = 1'b1;
          end
        end
        if (load_end && m_state[k] != 2) m_state[k] = 2;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_load_ready",  32'(a_load_ready),  32'(m_state[0] == 1 && m_cnt[0] < 256));
      chk("a_fetch_ready", 32'(a_fetch_ready), 32'(m_state[0] == 2));
      chk("a_load_count",  32'(a_load_count),  32'(m_cnt[0]));
      chk("a_load_ovf",    32'(a_load_ovf),    32'(m_ovf[0]));
      chk("a_instr_valid", 32'(a_instr_valid), 32'(m_valid[0]));
      chk("a_instr",       a_instr,            m_instr[0]);
      chk("a_fetch_fault", 32'(a_fetch_fault), 32'(m_fault[0]));
      chk("b_load_ready",  32'(b_load_ready),  32'(m_state[1] == 1 && m_cnt[1] < 16));
      chk("b_fetch_ready", 32'(b_fetch_ready), 32'(m_state[1] == 2));
      chk("b_load_count",  32'(b_load_count),  32'(m_cnt[1]));
      chk("b_load_ovf",    32'(b_load_ovf),    32'(m_ovf[1]));
      chk("b_instr_valid", 32'(b_instr_valid), 32'(m_valid[1]));
      chk("b_instr",       b_instr,            m_instr[1]);
      chk("b_fetch_fault", 32'(b_fetch_fault), 32'(m_fault[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit ls, input bit lv, input logic [7:0] lb,
                      input bit le, input bit fr, input logic [7:0] p);
    load_start = ls; load_valid = lv; load_byte = lb;
    load_end = le; fetch_req = fr; pc = p;
    @(posedge clk);
    #1;
    load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0; fetch_req = 1'b0;
  endtask

  logic [7:0] prog [8];
  logic [7:0] bb [17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h8C; prog[5] = 8'h09; prog[6] = 8'h00; prog[7] = 8'h04;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    chk("rst_count",  32'(a_load_count), 32'd0);
    chk("rst_valid",  32'(a_instr_valid), 32'd0);
    chk("rst_instr",  a_instr, 32'd0);
    chk("rst_ready",  32'(a_load_ready), 32'd0);

    // load 8 bytes, fetch pc=0 and pc=4 back-to-back
    step(1, 0, 8'h00, 0, 0, 8'd0);
    for (int i = 0; i < 8; i++) step(0, 1, prog[i], 0, 0, 8'd0);
    step(0, 0, 8'h00, 1, 0, 8'd0);
    chk("lit_count8", 32'(a_load_count), 32'd8);
    step(0, 0, 8'h00, 0, 1, 8'd0);
    chk("lit_be_pc0",    a_instr, 32'h20080005);
    chk("lit_le_pc0",    b_instr, 32'h05000820);
    chk("lit_fault_pc0", 32'(a_fetch_fault), 32'd0);
    step(0, 0, 8'h00, 0, 1, 8'd4);
    chk("lit_be_pc4",  a_instr, 32'h8C090004);
    chk("lit_vld_pc4", 32'(a_instr_valid), 32'd1);

    // faults
    step(0, 0, 8'h00, 0, 1, 8'd2);
    chk("lit_fault_pc2", 32'(a_fetch_fault), 32'd1);
    chk("lit_instr_pc2", a_instr, 32'd0);
    step(0, 0, 8'h00, 0, 1, 8'd8);
    chk("lit_fault_pc8", 32'(a_fetch_fault), 32'd2);
    step(0, 0, 8'h00, 0, 1, 8'd6);
    chk("lit_fault_pc6", 32'(b_fetch_fault), 32'd3);
    chk("lit_instr_pc6", b_instr, 32'd0);

    // reload while fetching
    step(1, 0, 8'h00, 0, 1, 8'd0);
    chk("lit_reload_vld",   32'(a_instr_valid), 32'd1);
    chk("lit_reload_instr", a_instr, 32'h20080005);
    chk("lit_reload_frdy",  32'(a_fetch_ready), 32'd0);
    chk("lit_reload_cnt",   32'(a_load_count), 32'd0);

    // 17 bytes: B (16 deep) fills and overflows
    for (int i = 0; i < 17; i++) begin
      bb[i] = 8'($urandom);
      step(0, 1, bb[i], 0, 0, 8'd0);
      if (i == 15) chk("lit_b_full_rdy", 32'(b_load_ready), 32'd0);
    end
    chk("lit_b_cnt16", 32'(b_load_count), 32'd16);
    chk("lit_b_ovf",   32'(b_load_ovf), 32'd1);
    chk("lit_a_cnt17", 32'(a_load_count), 32'd17);
    step(0, 0, 8'h00, 1, 0, 8'd0);
    step(0, 0, 8'h00, 0, 1, 8'd12);
    chk("lit_b_pc12", b_instr, {bb[15], bb[14], bb[13], bb[12]});
    chk("lit_a_pc12", a_instr, {bb[12], bb[13], bb[14], bb[15]});

    // load_start + load_end together stays in LOAD
    step(1, 0, 8'h00, 0, 0, 8'd0);
    step(1, 0, 8'h00, 1, 0, 8'd0);
    chk("lit_start_end_rdy",  32'(a_load_ready), 32'd1);
    chk("lit_start_end_frdy", 32'(a_fetch_ready), 32'd0);

    // async reset mid-load
    for (int i = 0; i < 3; i++) step(0, 1, prog[i], 0, 0, 8'd0);
    #2 rst = 1'b0;
    #1;
    chk("lit_arst_rdy", 32'(a_load_ready), 32'd0);
    chk("lit_arst_vld", 32'(a_instr_valid), 32'd0);
    chk("lit_arst_cnt", 32'(a_load_count), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 8'h00, 1, 0, 8'd0);
    step(0, 0, 8'h00, 0, 1, 8'd0);
    chk("lit_arst_fault", 32'(a_fetch_fault), 32'd2);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit ls, lv, le, fr;
      logic [7:0] p;
      ls = ($urandom_range(0, 99) < 2);
      le = ($urandom_range(0, 99) < 3);
      lv = ($urandom_range(0, 99) < 55);
      fr = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 9) < 7) p = 8'($urandom_range(0, 72)) & 8'hFC;
      else                          p = 8'($urandom);
      step(ls, lv, 8'($urandom), le, fr, p);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
